// File: rtl/qea_state_reader.sv
// State-RAM read-back engine: sweeps every state RAM row after a QEA run and streams
// each lane out as a single amplitude tagged with its basis-state index.
module qea_state_reader #(
  parameter int unsigned PE_NUM_WIDTH     = 2,
  parameter int unsigned PE_NUM           = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned STATE_DATA_WIDTH = DATA_WIDTH * 2,
  parameter int unsigned STATE_ADDR_WIDTH = 16,
  parameter int unsigned MAX_QBIT_WIDTH   = 6,
  parameter int unsigned RD_LATENCY       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_complete,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_amp_valid,
  input  logic                                 i_amp_ready,
  output logic [STATE_DATA_WIDTH-1:0]          o_amp_data,
  output logic [MAX_QBIT_WIDTH-1:0]            o_amp_idx,
  output logic                                 o_amp_last,
  output logic                                 o_busy,
  output logic                                 o_done
);

  localparam int unsigned WaitW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_LATENCY - 1);
  localparam logic [MAX_QBIT_WIDTH-1:0] PeNumW = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);

  typedef enum logic [2:0] {StIdle, StWaitCpl, StReq, StWait, StSend, StDone} state_e;

  state_e                              state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0]           n_q, n_d;
  logic [STATE_ADDR_WIDTH-1:0]         row_q, row_d;
  logic [STATE_ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [PE_NUM_WIDTH-1:0]             lane_q, lane_d;
  logic [MAX_QBIT_WIDTH-1:0]           idx_q, idx_d;
  logic [WaitW-1:0]                    wcnt_q, wcnt_d;
  logic [PE_NUM*STATE_DATA_WIDTH-1:0]  line_q, line_d;

  logic [STATE_ADDR_WIDTH-1:0]         last_row;
  logic [PE_NUM_WIDTH-1:0]             last_lane;
  logic                                lane_end, row_end;

  // Fewer than PE_NUM amplitudes in total means a single, partially used row.
  always_comb begin
    if (n_q >= PeNumW) begin
      last_lane = '1;
      last_row  = STATE_ADDR_WIDTH'((64'd1 << (n_q - PeNumW)) - 64'd1);
    end else begin
      last_lane = PE_NUM_WIDTH'((32'd1 << n_q) - 32'd1);
      last_row  = '0;
    end
  end

  assign lane_end = (lane_q == last_lane);
  assign row_end  = (row_q == last_row);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StWaitCpl;
          n_d     = i_qbit_num;
          row_d   = '0;
          idx_d   = '0;
        end
      end
      StWaitCpl: begin
        if (i_complete) state_d = StReq;
      end
      StReq: begin
        state_d = StWait;
        wcnt_d  = '0;
      end
      StWait: begin
        if (wcnt_q == WaitLast) begin
          line_d  = i_state_dout;
          lane_d  = '0;
          state_d = StSend;
        end else begin
          wcnt_d = wcnt_q + WaitW'(1);
        end
      end
      StSend: begin
        if (i_amp_ready) begin
          lane_d = lane_q + PE_NUM_WIDTH'(1);
          idx_d  = idx_q + MAX_QBIT_WIDTH'(1);
          if (lane_end) begin
            if (row_end) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + STATE_ADDR_WIDTH'(1);
              state_d = StReq;
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Address only moves on entry to a request so it holds between requests.
    if (state_d == StReq) addr_d = row_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      line_q  <= line_d;
    end
  end

  // Lane 0 is the most significant slice of the row.
  always_comb begin
    o_amp_data = '0;
    for (int p = 0; p < PE_NUM; p++) begin
      if (lane_q == PE_NUM_WIDTH'(p)) begin
        o_amp_data = line_q[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH];
      end
    end
  end

  assign o_state_ena   = {PE_NUM{state_q == StReq}};
  assign o_state_wea   = '0;
  assign o_state_addra = addr_q;
  assign o_amp_valid   = (state_q == StSend);
  assign o_amp_idx     = idx_q;
  assign o_amp_last    = (state_q == StSend) && lane_end && row_end;
  assign o_busy        = (state_q != StIdle);
  assign o_done        = (state_q == StDone);

endmodule

// File: tb/tb_qea_state_reader.sv
// Scoreboard bench for qea_state_reader: stimulus pushes expected beats, a negedge monitor
// pops and compares every handshake, and checks stall stability and done timing.
module tb_qea_state_reader;

  typedef struct packed {
    logic [63:0] d;
    logic [5:0]  idx;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic         i_complete = 1'b1;
  logic [3:0]   o_state_ena, o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] ram_dout;
  logic         o_amp_valid;
  logic         i_amp_ready = 1'b1;
  logic [63:0]  o_amp_data;
  logic [5:0]   o_amp_idx;
  logic         o_amp_last, o_busy, o_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int last_hs_cyc = -10;
  int rdy_toggle = 0;
  beat_t sb[$];
  logic [15:0] req_q[$];
  logic [255:0] mem [16];

  qea_state_reader dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_qbit_num   (i_qbit_num),
    .i_complete   (i_complete),
    .o_state_ena  (o_state_ena),
    .o_state_wea  (o_state_wea),
    .o_state_addra(o_state_addra),
    .i_state_dout (ram_dout),
    .o_amp_valid  (o_amp_valid),
    .i_amp_ready  (i_amp_ready),
    .o_amp_data   (o_amp_data),
    .o_amp_idx    (o_amp_idx),
    .o_amp_last   (o_amp_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle read latency state RAM
  always @(posedge clk) begin
    if (rst) ram_dout <= '0;
    else if (|o_state_ena) ram_dout <= mem[o_state_addra[3:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] amp(input int i);
    return {32'h1111_0000 + 32'(i), 32'hCAFE_0000 + 32'(i * 3)};
  endfunction

  task automatic fill_pattern();
    for (int r = 0; r < 16; r++) mem[r] = {amp(4*r), amp(4*r+1), amp(4*r+2), amp(4*r+3)};
  endtask

  task automatic expect_sweep(input int n);
    int total;
    total = 1 << n;
    for (int i = 0; i < total; i++) sb.push_back('{amp(i), 6'(i), i == total - 1});
  endtask

  task automatic start_sweep(input int n);
    @(posedge clk); #1;
    i_qbit_num = 6'(n);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int got;
    got = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1;
        break;
      end
    end
    check(name, 64'(got), 64'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ena"},   64'(o_state_ena), 64'd0);
    check({name, "_wea"},   64'(o_state_wea), 64'd0);
    check({name, "_addr"},  64'(o_state_addra), 64'd0);
    check({name, "_valid"}, 64'(o_amp_valid), 64'd0);
    check({name, "_data"},  o_amp_data, 64'd0);
    check({name, "_idx"},   64'(o_amp_idx), 64'd0);
    check({name, "_last"},  64'(o_amp_last), 64'd0);
    check({name, "_busy"},  64'(o_busy), 64'd0);
    check({name, "_done"},  64'(o_done), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_toggle != 0) i_amp_ready = ~i_amp_ready;
      else i_amp_ready = 1'b1;
    end
  end

  // Monitor: handshakes, stall stability, request tracking and done timing
  initial begin
    beat_t e, held;
    logic stall, prev_done;
    stall = 1'b0;
    prev_done = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (|o_state_ena) begin
          req_q.push_back(o_state_addra);
          check("req_ena_all", 64'(o_state_ena), 64'hF);
          check("req_wea_zero", 64'(o_state_wea), 64'd0);
        end
        if (stall) begin
          check("stall_valid", 64'(o_amp_valid), 64'd1);
          check("stall_data", o_amp_data, held.d);
          check("stall_idx", 64'(o_amp_idx), 64'(held.idx));
          check("stall_last", 64'(o_amp_last), 64'(held.last));
          stall = 1'b0;
        end
        if (o_amp_valid) begin
          if (i_amp_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL beat_unexpected actual_idx=%0d required=no_beat", o_amp_idx);
            end else begin
              e = sb.pop_front();
              check("beat_data", o_amp_data, e.d);
              check("beat_idx", 64'(o_amp_idx), 64'(e.idx));
              check("beat_last", 64'(o_amp_last), 64'(e.last));
            end
            hs_cnt++;
            last_hs_cyc = cyc;
          end else begin
            stall = 1'b1;
            held = '{o_amp_data, o_amp_idx, o_amp_last};
          end
        end
        if (prev_done) check("done_one_cycle", 64'(o_done), 64'd0);
        if (o_done) begin
          done_cnt++;
          check("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
        end
        prev_done = o_done;
      end
    end
  end

  initial begin
    int k, hs0, dn0, reqs0;
    #1;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // n=3 with a single 1.0 amplitude in the MSB lane of row 0
    for (int r = 0; r < 16; r++) mem[r] = '0;
    mem[0] = {64'h4000_0000_0000_0000, 64'd0, 64'd0, 64'd0};
    sb.push_back('{64'h4000_0000_0000_0000, 6'd0, 1'b0});
    for (int i = 1; i < 8; i++) sb.push_back('{64'd0, 6'(i), i == 7});
    req_q.delete();
    hs0 = hs_cnt;
    start_sweep(3);
    k = 0;
    while (k < 20 && !o_amp_valid) begin
      @(posedge clk); #1;
      k++;
    end
    check("first_valid_latency", 64'(k), 64'd3);
    wait_done("t1_done", 100);
    check("t1_beats", 64'(hs_cnt - hs0), 64'd8);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    check("t1_req_count", 64'(req_q.size()), 64'd2);
    if (req_q.size() == 2) begin
      check("t1_req_addr0", 64'(req_q[0]), 64'd0);
      check("t1_req_addr1", 64'(req_q[1]), 64'd1);
    end
    @(posedge clk); #1;
    check("t1_idle_busy", 64'(o_busy), 64'd0);

    // i_complete held low for 10 cycles
    fill_pattern();
    req_q.delete();
    i_complete = 1'b0;
    expect_sweep(3);
    start_sweep(3);
    repeat (10) @(posedge clk);
    #1;
    check("t2_no_req_while_low", 64'(req_q.size()), 64'd0);
    check("t2_busy_waiting", 64'(o_busy), 64'd1);
    i_complete = 1'b1;
    @(posedge clk); #1;
    check("t2_req_after_rise", 64'(o_state_ena), 64'hF);
    wait_done("t2_done", 100);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // ready toggling, with i_complete dropping mid-sweep
    rdy_toggle = 1;
    hs0 = hs_cnt;
    expect_sweep(3);
    start_sweep(3);
    repeat (6) @(posedge clk);
    #1;
    i_complete = 1'b0;
    wait_done("t3_done", 200);
    check("t3_beats", 64'(hs_cnt - hs0), 64'd8);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    rdy_toggle = 0;
    i_complete = 1'b1;

    // n=1: a single partially used row
    req_q.delete();
    hs0 = hs_cnt;
    expect_sweep(1);
    start_sweep(1);
    wait_done("t4_done", 100);
    check("t4_beats", 64'(hs_cnt - hs0), 64'd2);
    check("t4_req_count", 64'(req_q.size()), 64'd1);
    if (req_q.size() == 1) check("t4_req_addr", 64'(req_q[0]), 64'd0);

    // n=4 with reset asserted during row 2
    dn0 = done_cnt;
    expect_sweep(4);
    start_sweep(4);
    k = 0;
    while (k < 200 && !(o_state_ena != 0 && o_state_addra == 16'd2)) begin
      @(negedge clk);
      k++;
    end
    check("t5_reach_row2", 64'(k < 200), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("t5_abort");
    sb.delete();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    check("t5_no_done", 64'(done_cnt - dn0), 64'd0);
    req_q.delete();
    hs0 = hs_cnt;
    expect_sweep(4);
    start_sweep(4);
    wait_done("t5_restart_done", 200);
    check("t5_restart_beats", 64'(hs_cnt - hs0), 64'd16);
    check("t5_req_count", 64'(req_q.size()), 64'd4);
    if (req_q.size() > 0) check("t5_first_addr", 64'(req_q[0]), 64'd0);

    // Second i_start and a new i_qbit_num mid-sweep are ignored
    dn0 = done_cnt;
    hs0 = hs_cnt;
    expect_sweep(2);
    start_sweep(2);
    repeat (3) @(posedge clk);
    #1;
    i_qbit_num = 6'd5;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done("t6_done", 100);
    repeat (10) @(posedge clk);
    #1;
    check("t6_beats", 64'(hs_cnt - hs0), 64'd4);
    check("t6_single_done", 64'(done_cnt - dn0), 64'd1);
    check("t6_idle", 64'(o_busy), 64'd0);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
